// File: rtl/mips_core_pkg.sv
// Shared core-wide widths and types used by the front-end blocks,
// including the instruction-queue depth defaults and entry layout.
package mips_core_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDR_WIDTH        = 32;

    localparam int INST_Q_DEPTH      = 8;
    localparam int INST_Q_DEPTH_BITS = 3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] pc;
    } InstQEntry;

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of fetched {instruction, PC} pairs between the i-cache and
// decode; lets fetch run ahead of decode stalls and drops everything on flush.
module inst_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = INST_Q_DEPTH,
    parameter int DEPTH_BITS = INST_Q_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  deq,
    input  logic                  flush,
    output logic                  out_valid,
    output logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DEPTH_BITS:0]   count
);

    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [DEPTH_BITS-1:0] head_q, head_d;
    logic [DEPTH_BITS-1:0] tail_q, tail_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    InstQEntry             mem_q [DEPTH];

    logic push, pop;

    // Full blocks a push even when decode frees a slot in the same cycle.
    assign push = in_valid && !out_full && !flush;
    assign pop  = deq && out_valid && !flush;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is reset so the head outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[tail_q] <= '{data: in_data, pc: in_pc};
        end
    end

    assign out_valid = (count_q != '0);
    assign out_full  = (count_q == FULL_COUNT);
    assign out_data  = mem_q[head_q].data;
    assign out_pc    = mem_q[head_q].pc;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver queues expected entries as it
// pushes, and a negedge monitor compares the head whenever decode consumes it.
module tb_inst_queue;
    import mips_core_pkg::*;

    localparam int DEPTH = INST_Q_DEPTH;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic                  deq;
    logic                  flush;
    logic                  out_valid;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [INST_Q_DEPTH_BITS:0] count;

    inst_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .deq       (deq),
        .flush     (flush),
        .out_valid (out_valid),
        .out_full  (out_full),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    InstQEntry exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Called at posedge+1: verify state against the model, then drive one cycle.
    task automatic step(input logic v, input logic [31:0] pc, input logic dq, input logic fl);
        check("count", 64'(count), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("out_full", 64'(out_full), 64'(exp_q.size() == DEPTH));
        in_valid = v;
        in_pc    = pc;
        in_data  = data_of(pc);
        deq      = dq;
        flush    = fl;
        if (fl) exp_q.delete();
        else if (v && exp_q.size() < DEPTH) exp_q.push_back('{data: data_of(pc), pc: pc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        deq      = 1'b0;
        flush    = 1'b0;
    endtask

    // Monitor: decode consumes the head on this cycle's edge.
    initial begin
        InstQEntry e;
        forever begin
            @(negedge clk);
            if (rst_n && deq && out_valid && !flush) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("head_pc", 64'(out_pc), 64'(e.pc));
                    check("head_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_pc    = '0;
        deq      = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic push: three words, no dequeue.
        step(1'b1, 32'h0040_0000, 1'b0, 1'b0);
        check("basic_valid_after_1", 64'(out_valid), 64'd1);
        check("basic_head_pc_1", 64'(out_pc), 64'h0040_0000);
        step(1'b1, 32'h0040_0004, 1'b0, 1'b0);
        step(1'b1, 32'h0040_0008, 1'b0, 1'b0);
        check("basic_count", 64'(count), 64'd3);
        check("basic_head_pc", 64'(out_pc), 64'h0040_0000);
        check("basic_head_data", 64'(out_data), 64'h8589_0000 ^ 64'h0040_0000 ^ 64'h8589_0000 ^ 64'hA5A5_0000);

        // Asynchronous reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_full", 64'(out_full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill to full, then a push with deq while full is dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0040_0000 + 32'(i * 4), 1'b0, 1'b0);
        check("full_flag", 64'(out_full), 64'd1);
        check("full_count", 64'(count), 64'd8);
        step(1'b1, 32'h0040_0020, 1'b1, 1'b0);
        check("drop_count", 64'(count), 64'd7);
        check("drop_not_full", 64'(out_full), 64'd0);
        check("drop_head_pc", 64'(out_pc), 64'h0040_0004);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_count", 64'(count), 64'd0);

        // Steady state across pointer wrap.
        pc = 32'h0040_1000;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pc, 1'b0, 1'b0);
            pc += 32'd4;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, pc, 1'b1, 1'b0);
            pc += 32'd4;
            check("steady_count", 64'(count), 64'd4);
        end
        check("steady_head_pc", 64'(out_pc), 64'h0040_1050);

        // Flush at count 5 overrides simultaneous push and pop.
        step(1'b1, pc, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count), 64'd5);
        step(1'b1, 32'h0040_0200, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_full", 64'(out_full), 64'd0);
        step(1'b1, 32'h0040_0100, 1'b0, 1'b0);
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_pc", 64'(out_pc), 64'h0040_0100);
        check("post_flush_count", 64'(count), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Dequeue while empty is ignored; the same-cycle push lands.
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("empty_deq_count", 64'(count), 64'd0);
        step(1'b1, 32'h0040_0300, 1'b1, 1'b0);
        check("empty_push_count", 64'(count), 64'd1);
        check("empty_push_pc", 64'(out_pc), 64'h0040_0300);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("final_count", 64'(count), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the i-cache and decode/rename in the out-of-order core. It buffers fetched instruction words with their PCs in a circular FIFO, so fetch runs ahead while decode stalls on ROB or reservation-station full. On a mispredict flush it drops all buffered instructions. Its input side matches `i_cache_output_ifc` and its output side drives `inst_q_output_ifc`.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two and at least 2.
- `DEPTH_BITS`, 3: log2(DEPTH).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  i-cache output valid (`i_cache_output_ifc.valid`).
- `in_data`  in  DATA_WIDTH  fetched instruction word.
- `in_pc`  in  ADDR_WIDTH  PC of the fetched word.
- `deq`  in  1  decode consumes the head entry this cycle.
- `flush`  in  1  mispredict flush (`branch_pred_hc_ifc.flush`).
- `out_valid`  out  1  head entry valid (`inst_q_output_ifc.valid`).
- `out_full`  out  1  queue full; fetch must stall (`inst_q_output_ifc.full`).
- `out_data`  out  DATA_WIDTH  head instruction word.
- `out_pc`  out  ADDR_WIDTH  head PC.
- `count`  out  DEPTH_BITS+1  occupancy, 0..DEPTH.

## Operation
- Storage:
  - DEPTH entries of {data, pc}.
  - Head and tail pointers are DEPTH_BITS wide and wrap modulo DEPTH.
  - `count` register is DEPTH_BITS+1 wide.
- Push: occurs when `in_valid && !out_full && !flush`. Writes entry[tail] and increments tail.
- Push when full: if `in_valid` is high while `out_full` is high, the word is dropped. This holds even if `deq` is high in the same cycle. Fetch is required to hold its PC while `out_full` is high.
- Pop: occurs when `deq && out_valid && !flush`. Increments head.
  - `deq` while empty is ignored.
  - There is no bypass: a word pushed this cycle cannot be popped this cycle.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Otherwise: `count` increments on push-only and decrements on pop-only.
- Flush:
  - Synchronous. Head, tail and `count` go to 0.
  - Overrides push and pop in the same cycle; the incoming word is dropped.
  - Storage contents are not cleared.
- Outputs are combinational from registered state:
  - `out_valid` = (`count` != 0).
  - `out_full` = (`count` == DEPTH).
  - `out_data` and `out_pc` = entry[head].
- Reset (`rst_n` low, asynchronous): pointers, `count` and all storage go to 0. Hence `out_valid`=0, `out_full`=0, `out_data`=0, `out_pc`=0, `count`=0.
- Invariants:
  - `count` never exceeds DEPTH and never underflows.
  - Entries are popped in strict push order across pointer wrap-around.

## Timing
- Push to visible at head: 1 cycle. A word pushed at edge N appears on `out_*` after edge N when the queue was empty.
- Pop: the next head appears after the same edge that pops.
- `out_full` asserts the cycle after the DEPTH-th push and deasserts the cycle after the first pop from full.
- Flush: `out_valid`=0 and `out_full`=0 the cycle after the flush edge. A push on the following cycle is visible one cycle later.
- Reset: outputs clear immediately on `rst_n` falling, independent of `clk`. Normal operation resumes on the first rising edge after `rst_n` rises.
- No combinational path exists from any input to any output.

## Structure
- Add `INST_Q_DEPTH` = 8 and `INST_Q_DEPTH_BITS` = 3 to `mips_core_pkg`. These are the defaults for `DEPTH` and `DEPTH_BITS`.
- Add `InstQEntry` to `mips_core_pkg`: a packed struct of {`data` DATA_WIDTH, `pc` ADDR_WIDTH}.
- Single module with no sub-module. Storage is a register array of `InstQEntry`.

## Test plan
- Reset: drive `rst_n` low mid-cycle → `out_valid`=0, `out_full`=0, `count`=0 and `out_pc`=0, with no clock edge needed.
- Basic push: push {0x20080001, 0x00400000}, {0x20090002, 0x00400004}, {0x012A4020, 0x00400008}, `deq`=0 → `out_valid`=1 one cycle after the first push; head `out_pc`=0x00400000; `count`=3.
- Full and drop: push 8 words with PCs 0x00400000..0x0040001C → `out_full`=1 and `count`=8. Then push PC 0x00400020 with `deq`=1 in the same cycle → that word is dropped and `count`=7. Draining yields PCs 0x00400004..0x0040001C in order; 0x00400020 never appears.
- Steady state and wrap-around: at `count`=4, hold `in_valid`=1 and `deq`=1 for 20 cycles with incrementing PCs → `count` stays 4 throughout, and popped PCs form a gap-free sequence across pointer wrap.
- Flush priority: at `count`=5, assert `flush` with `in_valid`=1 and `deq`=1 → next cycle `count`=0, `out_valid`=0, `out_full`=0. A following push of PC 0x00400100 appears at head one cycle later.
- Empty pop: `deq`=1 with `count`=0 → no state change. A push in the same cycle gives `count`=1 next cycle and the head is that word.
